// File: rtl/ex_div_pkg.sv
// Shared encodings for the execute-stage iterative divider: FSM states,
// RV32M divide op codes and handshake levels.
package ex_div_pkg;

    localparam int REG_WIDTH = 32;

    typedef enum logic [1:0] {
        DivIdle = 2'b00,
        DivCalc = 2'b01,
        DivDone = 2'b10
    } div_state_e;

    localparam logic [1:0] DIV_OP_DIV  = 2'b00;
    localparam logic [1:0] DIV_OP_DIVU = 2'b01;
    localparam logic [1:0] DIV_OP_REM  = 2'b10;
    localparam logic [1:0] DIV_OP_REMU = 2'b11;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    function automatic logic op_is_signed(input logic [1:0] op);
        case (op)
            DIV_OP_DIV, DIV_OP_REM:   return 1'b1;
            DIV_OP_DIVU, DIV_OP_REMU: return 1'b0;
            default:                  return 1'b0;
        endcase
    endfunction

    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
    endfunction

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved at acceptance.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = REG_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             annul_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ready_o,
    output logic             stall_req_o
);

    localparam logic [5:0]       LAST_ITER = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] result_d;
    logic             ready_d;

    logic             signed_in;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             overflow;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic [WIDTH-1:0] fix_q, fix_r;

    assign signed_in = op_is_signed(op_i);
    assign a_neg     = signed_in & dividend_i[WIDTH-1];
    assign b_neg     = signed_in & divisor_i[WIDTH-1];
    assign a_mag     = a_neg ? -dividend_i : dividend_i;
    assign b_mag     = b_neg ? -divisor_i : divisor_i;
    assign overflow  = signed_in && (dividend_i == MOST_NEG) && (divisor_i == '1);

    // The shifted-in remainder can reach 2*divisor-1, hence the extra bit.
    assign trial    = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dsr_q};
    assign step_rem = trial[WIDTH] ? {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]} : trial[WIDTH-1:0];
    assign step_quo = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
    assign fix_q    = (op_is_signed(op_q) && neg_q_q) ? -step_quo : step_quo;
    assign fix_r    = (op_is_signed(op_q) && neg_r_q) ? -step_rem : step_rem;

    assign stall_req_o = start_i & ~ready_o & ~annul_i;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        result_d = result_o;
        ready_d  = ready_o;
        if (annul_i) begin
            state_d  = DivIdle;
            result_d = '0;
            ready_d  = DivResultNotReady;
        end else begin
            case (state_q)
                DivIdle: begin
                    if (start_i == DivStart) begin
                        op_d    = op_i;
                        neg_q_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
                        neg_r_d = dividend_i[WIDTH-1];
                        cnt_d   = '0;
                        rem_d   = '0;
                        dvd_d   = a_mag;
                        dsr_d   = b_mag;
                        if (divisor_i == '0) begin
                            state_d  = DivDone;
                            result_d = op_is_rem(op_i) ? dividend_i : '1;
                            ready_d  = DivResultReady;
                        end else if (overflow) begin
                            state_d  = DivDone;
                            result_d = op_is_rem(op_i) ? '0 : MOST_NEG;
                            ready_d  = DivResultReady;
                        end else begin
                            state_d = DivCalc;
                        end
                    end
                end
                DivCalc: begin
                    rem_d = step_rem;
                    dvd_d = step_quo;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d  = DivDone;
                        result_d = op_is_rem(op_q) ? fix_r : fix_q;
                        ready_d  = DivResultReady;
                    end
                end
                DivDone: begin
                    if (start_i == DivStop) begin
                        state_d  = DivIdle;
                        result_d = '0;
                        ready_d  = DivResultNotReady;
                    end
                end
                default: begin
                    state_d  = DivIdle;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= DivIdle;
            op_q     <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            cnt_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            result_o <= result_d;
            ready_o  <= ready_d;
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Directed self-checking bench for ex_div: latency, stall window, signed fixups,
// special cases, annul and asynchronous reset.
module tb_ex_div;
    import ex_div_pkg::*;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        annul_i;
    logic [31:0] result_o;
    logic        ready_o;
    logic        stall_req_o;

    int checks = 0;
    int fails  = 0;

    ex_div #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .stall_req_o (stall_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives a request (from posedge+1) and waits for ready, counting cycles
    // after acceptance and cycles with stall asserted. Operand buses are
    // scrambled after the accept edge.
    task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output int lat, output int stalls);
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        start_i    = 1'b1;
        lat        = 0;
        stalls     = 0;
        #1;
        if (stall_req_o) stalls++;
        while (!ready_o && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                dividend_i = 32'hDEAD_BEEF;
                divisor_i  = 32'h0000_0003;
            end
            if (stall_req_o) stalls++;
        end
        res = result_o;
    endtask

    task automatic drop_start();
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        start_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset_outputs ready=%b result=%h required ready=0 result=0", ready_o, result_o);
        end
        checks++;
        if (stall_req_o !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_stall_comb stall=%b required 1", stall_req_o);
        end
        start_i = 1'b0;
        #1;
        checks++;
        if (stall_req_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_stall_idle stall=%b required 0", stall_req_o);
        end
    endtask

    task automatic test_divu_basic();
        logic [31:0] res;
        int lat, stalls;
        run_div(DIV_OP_DIVU, 32'd100, 32'd7, res, lat, stalls);
        checks++;
        if (res !== 32'd14 || lat != 33) begin
            fails++;
            $display("[TB] FAIL divu_100_7 result=%h latency=%0d required 0000000e latency 33", res, lat);
        end
        checks++;
        if (stalls != 33 || stall_req_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL divu_stall_window stall_cycles=%0d stall_now=%b required 33 and 0", stalls, stall_req_o);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b1 || result_o !== 32'd14) begin
            fails++;
            $display("[TB] FAIL divu_hold ready=%b result=%h required 1 0000000e", ready_o, result_o);
        end
        drop_start();
        checks++;
        if (ready_o !== 1'b0 || result_o !== 32'h0) begin
            fails++;
            $display("[TB] FAIL divu_release ready=%b result=%h required 0 0", ready_o, result_o);
        end
    endtask

    task automatic test_signed_ops();
        logic [1:0]  ops  [6] = '{DIV_OP_DIV, DIV_OP_REM, DIV_OP_REMU, DIV_OP_DIV, DIV_OP_REM, DIV_OP_DIVU};
        logic [31:0] as   [6] = '{32'hFFFF_FFEC, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'h8000_0000};
        logic [31:0] bs   [6] = '{32'd3, 32'd2, 32'd16, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        logic [31:0] exps [6] = '{32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'd15, 32'hFFFF_FFFD, 32'd1, 32'd0};
        logic [31:0] res;
        int lat, stalls;
        for (int i = 0; i < 6; i++) begin
            run_div(ops[i], as[i], bs[i], res, lat, stalls);
            checks++;
            if (res !== exps[i] || lat != 33) begin
                fails++;
                $display("[TB] FAIL signed_vec%0d result=%h latency=%0d required %h latency 33", i, res, lat, exps[i]);
            end
            drop_start();
        end
    endtask

    task automatic test_special_cases();
        logic [1:0]  ops  [6] = '{DIV_OP_DIVU, DIV_OP_REM, DIV_OP_DIV, DIV_OP_REMU, DIV_OP_DIV, DIV_OP_REM};
        logic [31:0] as   [6] = '{32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs   [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps [6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h8000_0000, 32'd0};
        logic [31:0] res;
        int lat, stalls;
        for (int i = 0; i < 6; i++) begin
            run_div(ops[i], as[i], bs[i], res, lat, stalls);
            checks++;
            if (res !== exps[i] || lat != 1 || stalls != 1) begin
                fails++;
                $display("[TB] FAIL special_vec%0d result=%h latency=%0d stalls=%0d required %h latency 1 stalls 1",
                         i, res, lat, stalls, exps[i]);
            end
            drop_start();
        end
    endtask

    task automatic test_annul();
        logic [31:0] res;
        int lat, stalls;
        op_i       = DIV_OP_DIVU;
        dividend_i = 32'd1000;
        divisor_i  = 32'd7;
        start_i    = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(posedge clk);
            #1;
        end
        annul_i = 1'b1;
        #1;
        checks++;
        if (stall_req_o !== 1'b0) begin
            fails++;
            $display("[TB] FAIL annul_stall stall=%b required 0", stall_req_o);
        end
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 32'h0) begin
            fails++;
            $display("[TB] FAIL annul_flush ready=%b result=%h required 0 0", ready_o, result_o);
        end
        run_div(DIV_OP_DIVU, 32'd9, 32'd3, res, lat, stalls);
        checks++;
        if (res !== 32'd3 || lat != 33) begin
            fails++;
            $display("[TB] FAIL annul_restart result=%h latency=%0d required 00000003 latency 33", res, lat);
        end
        // Annul arriving with the result already valid discards it.
        annul_i = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 32'h0) begin
            fails++;
            $display("[TB] FAIL annul_done ready=%b result=%h required 0 0", ready_o, result_o);
        end
        annul_i = 1'b0;
        drop_start();
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int lat, stalls;
        run_div(DIV_OP_DIVU, 32'd50, 32'd5, res, lat, stalls);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 32'h0) begin
            fails++;
            $display("[TB] FAIL async_reset_done ready=%b result=%h required 0 0", ready_o, result_o);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        op_i       = DIV_OP_DIVU;
        dividend_i = 32'd1000;
        divisor_i  = 32'd7;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (ready_o !== 1'b0 || result_o !== 32'h0 || dut.state_q !== DivIdle) begin
            fails++;
            $display("[TB] FAIL async_reset_calc ready=%b result=%h state=%0d required 0 0 idle",
                     ready_o, result_o, dut.state_q);
        end
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_div(DIV_OP_DIVU, 32'd1, 32'd1, res, lat, stalls);
        checks++;
        if (res !== 32'd1 || lat != 33) begin
            fails++;
            $display("[TB] FAIL post_reset_div result=%h latency=%0d required 00000001 latency 33", res, lat);
        end
        drop_start();
    endtask

    initial begin
        rst        = 1'b0;
        start_i    = 1'b0;
        op_i       = 2'b00;
        dividend_i = '0;
        divisor_i  = '0;
        annul_i    = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_divu_basic();
        test_signed_ops();
        test_special_cases();
        test_annul();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
